// File: rtl/pin_capture_pkg.sv
// Shared types and width helpers for the pin_capture logic-analyser front end.
// Optional feature macro: PIN_CAPTURE_TIMESTAMP_EN (timestamped FIFO entries).
package pin_capture_pkg;

`ifdef PIN_CAPTURE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Storage policy applied on each sample tick
    typedef enum logic {
        MODE_ALL    = 1'b0,
        MODE_CHANGE = 1'b1
    } cap_mode_e;

    // FIFO entry width: {timestamp, filtered} when timestamps are built, else {filtered}
    function automatic int entry_w(input int channels, input int ts_width);
        return TS_EN ? channels + ts_width : channels;
    endfunction

    // Occupancy counter width: must represent 0..DEPTH inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pin_capture_filter.sv
// pin_filter: one channel of 2-flop synchroniser followed by a hysteresis filter.
// The output only moves once the last FILTER_LEN synchronised samples agree.
module pin_filter
    import pin_capture_pkg::*;
#(
    parameter int FILTER_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filt
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] win;

    // Two-flop synchroniser for the asynchronous pin level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[0], pin};
    end

    // The window is the FILTER_LEN-1 stored samples plus the newest synchronised one,
    // so a clean edge reaches filt after 2+FILTER_LEN cycles.
    generate
        if (FILTER_LEN == 1) begin : g_nohist
            assign win = sync[1];
        end else begin : g_hist
            logic [FILTER_LEN-2:0] hist;

            // Sample history shift register
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) hist <= '0;
                else      hist <= win[FILTER_LEN-2:0];
            end

            assign win = {hist, sync[1]};
        end
    endgenerate

    // Hysteresis: follow only unanimous windows, otherwise hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        filt <= 1'b0;
        else if (&win)   filt <= 1'b1;
        else if (~|win)  filt <= 1'b0;
    end

endmodule

// File: rtl/pin_capture.sv
// pin_capture: synchronise + glitch-filter the pin bank, sample on a programmable
// tick and queue snapshots in a first-word-fall-through FIFO for the SPI side.
// Optional feature macro: PIN_CAPTURE_TIMESTAMP_EN adds a wrapping timestamp to each
// entry and a mode-1 time-reference marker push when the timestamp is all ones.
module pin_capture
    import pin_capture_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int FILTER_LEN = 2,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CHANNELS-1:0]                    pins_in,
    input  logic                                   enable,
    input  logic [DIV_WIDTH-1:0]                   sample_div,
    input  logic                                   mode,
    input  logic                                   rd_en,
    output logic [entry_w(CHANNELS, TS_WIDTH)-1:0] rd_data,
    output logic                                   rd_valid,
    output logic [level_w(DEPTH)-1:0]              level,
    output logic                                   overflow,
    input  logic                                   clear_overflow,
    output logic [CHANNELS-1:0]                    filtered
);

    localparam int ENTRY_W = entry_w(CHANNELS, TS_WIDTH);
    localparam int LEVEL_W = level_w(DEPTH);
    localparam int PTR_W   = $clog2(DEPTH);

    // ---------------- per-channel front end ----------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            pin_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
                .clk  (clk),
                .rst  (rst),
                .pin  (pins_in[gi]),
                .filt (filtered[gi])
            );
        end
    endgenerate

    // ---------------- tick generator ----------------
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;

    // ">=" makes a sample_div lowered below div_cnt fire on the very next cycle
    assign tick = enable && (div_cnt >= sample_div);

    // Divider: held at 0 while stopped, restarts after every tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                div_cnt <= '0;
        else if (!enable || tick) div_cnt <= '0;
        else                     div_cnt <= div_cnt + DIV_WIDTH'(1);
    end

    // ---------------- run-start tracking ----------------
    logic en_q, first_pend, rise, first;

    assign rise  = enable && !en_q;
    assign first = rise || first_pend;

    // Remember that the first tick after enable rose has not happened yet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= 1'b0;
            first_pend <= 1'b0;
        end else begin
            en_q <= enable;
            if (tick)      first_pend <= 1'b0;
            else if (rise) first_pend <= 1'b1;
        end
    end

    // ---------------- timestamp / entry formation ----------------
    logic [ENTRY_W-1:0] entry;
    logic               marker;

`ifdef PIN_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt, ts_cur;

    // On the rise cycle the count is treated as 0 so a same-cycle tick stamps ts 0
    assign ts_cur = rise ? '0 : ts_cnt;
    assign marker = &ts_cur;
    assign entry  = {ts_cur, filtered};

    // Timestamp advances per tick and wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      ts_cnt <= '0;
        else if (tick) ts_cnt <= ts_cur + TS_WIDTH'(1);
        else if (rise) ts_cnt <= '0;
    end
`else
    assign marker = 1'b0;
    assign entry  = filtered;
`endif

    // ---------------- push decision ----------------
    logic [CHANNELS-1:0] last_push;
    logic                push_req;

    assign push_req = tick && ((cap_mode_e'(mode) == MODE_ALL) || (filtered != last_push)
                               || first || marker);

    // Last value offered to the FIFO, for change-only mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          last_push <= '0;
        else if (push_req) last_push <= filtered;
    end

    // ---------------- FIFO ----------------
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0] lvl;
    logic               full, do_pop, do_wr, drop;

    assign rd_valid = (lvl != '0);
    assign full     = (lvl == LEVEL_W'(DEPTH));
    assign do_pop   = rd_en && rd_valid;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts
    assign do_wr    = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;
    assign level    = lvl;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Storage array; contents are only observable through rd_valid, so no reset
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= entry;
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lvl      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_wr && !do_pop)      lvl <= lvl + LEVEL_W'(1);
            else if (!do_wr && do_pop) lvl <= lvl - LEVEL_W'(1);
            // A drop in the same cycle as a clear keeps the flag set
            if (drop)                 overflow <= 1'b1;
            else if (clear_overflow)  overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pin_capture.sv
// Randomised + directed bench for pin_capture with a scoreboard.
// Honours PIN_CAPTURE_TIMESTAMP_EN when it is defined for the build.
module tb_pin_capture;
    import pin_capture_pkg::*;

    localparam int CH    = 8;
    localparam int FL    = 2;
    localparam int DEPTH = 8;
    localparam int TSW   = 4;
    localparam int DW    = 8;
    localparam int EW    = entry_w(CH, TSW);
    localparam int LW    = level_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] pins_in = '0;
    logic          enable = 1'b0;
    logic [DW-1:0] sample_div = '0;
    logic          mode = 1'b0;
    logic          rd_en = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [EW-1:0] rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic          overflow;
    logic [CH-1:0] filtered;

    pin_capture #(
        .CHANNELS(CH), .FILTER_LEN(FL), .DEPTH(DEPTH), .TS_WIDTH(TSW), .DIV_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .pins_in(pins_in), .enable(enable),
        .sample_div(sample_div), .mode(mode), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .level(level), .overflow(overflow),
        .clear_overflow(clear_overflow), .filtered(filtered)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CH-1:0] hs [0:FL];   // hs[k]: pin vector presented k edges ago (0 = newest)
    logic [CH-1:0] m_filt, m_last;
    int            m_div, m_ts, m_lvl;
    bit            m_enq, m_first, m_ovf;
    logic [EW-1:0] sb [$];      // expected entries, oldest first

    task automatic reset_model();
        for (int k = 0; k <= FL; k++) hs[k] = '0;
        m_filt = '0; m_last = '0; m_div = 0; m_ts = 0; m_lvl = 0;
        m_enq = 0; m_first = 0; m_ovf = 0;
        sb.delete();
    endtask

    // Advance one clock and apply the spec rules to the inputs seen at that edge
    task automatic step();
        logic [CH-1:0] nf;
        logic [EW-1:0] e;
        bit tick, rise, first, marker, push, pop, full, a1, a0;
        int ts_cur;
        @(posedge clk);
        if (!rst) begin
            reset_model();
        end else begin
            // a bit settles only when every sample aged 2..FL+1 edges agrees
            nf = m_filt;
            for (int c = 0; c < CH; c++) begin
                a1 = 1; a0 = 1;
                for (int k = 1; k <= FL; k++) begin
                    if (hs[k][c]) a0 = 0; else a1 = 0;
                end
                if (a1) nf[c] = 1'b1; else if (a0) nf[c] = 1'b0;
            end
            tick   = enable && (m_div >= int'(sample_div));
            rise   = enable && !m_enq;
            first  = rise || m_first;
            ts_cur = rise ? 0 : m_ts;
`ifdef PIN_CAPTURE_TIMESTAMP_EN
            marker = (ts_cur == (1 << TSW) - 1);
            e      = {TSW'(ts_cur), m_filt};
`else
            marker = 0;
            e      = m_filt;
`endif
            push = tick && (mode == 1'b0 || m_filt != m_last || first || marker);
            pop  = rd_en && (m_lvl > 0);
            full = (m_lvl == DEPTH);
            if (push) begin
                m_last = m_filt;
                if (full && !pop) m_ovf = 1;
                else begin
                    sb.push_back(e);
                    m_lvl++;
                end
            end else if (clear_overflow) m_ovf = 0;
            if (push && !(full && !pop) && clear_overflow) m_ovf = 0;
            if (pop) m_lvl--;
            m_div   = (!enable || tick) ? 0 : m_div + 1;
            m_ts    = tick ? (ts_cur + 1) % (1 << TSW) : (rise ? 0 : m_ts);
            m_first = tick ? 0 : (rise ? 1 : m_first);
            m_enq   = enable;
            m_filt  = nf;
            for (int k = FL; k > 0; k--) hs[k] = hs[k-1];
            hs[0] = pins_in;
        end
        #2;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        chk("level", 32'(level), 32'(m_lvl));
        chk("rd_valid", 32'(rd_valid), 32'(m_lvl != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("filtered", 32'(filtered), 32'(m_filt));
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_data: got 0x%0h with no entry expected", rd_data);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(sb[0]));
                if (rd_en) void'(sb.pop_front());
            end
        end else begin
            chk("rd_data_idle", 32'(rd_data), 32'h0);
        end
    end

    task automatic drain();
        rd_en = 1'b1;
        for (int i = 0; i < 40 && level != '0; i++) step();
        rd_en = 1'b0;
        chk("drain_level", 32'(level), 32'h0);
    endtask

    int  lat;
    int  lvl0;
    bit  seen;

    initial begin
        reset_model();
        // reset held: outputs must stay zero whatever the pins do
        for (int i = 0; i < 3; i++) begin
            pins_in = CH'($urandom);
            step();
        end
        pins_in = '0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // pin-to-filtered latency
        pins_in = 8'hA5;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (filtered == 8'hA5 && lat < 0) lat = i;
        end
        chk("latency", 32'(lat), 32'(2 + FL));

        // glitch rejection in change-only mode
        mode = 1'b1; sample_div = 8'd1; enable = 1'b1;
        for (int i = 0; i < 4; i++) step();
        lvl0 = int'(level);
        pins_in = 8'hA4; step();
        pins_in = 8'hA5;
        for (int i = 0; i < 6; i++) step();
        chk("glitch_filtered", 32'(filtered), 32'hA5);
        chk("glitch_level", 32'(level), 32'(lvl0));
        pins_in = 8'hA4; step(); step();
        pins_in = 8'hA5;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!filtered[0]) seen = 1;
        end
        chk("pulse_seen", 32'(seen), 32'h1);
        enable = 1'b0;
        drain();

        // mode 0: every fourth cycle for 20 cycles
        mode = 1'b0; sample_div = 8'd3; enable = 1'b1;
        for (int i = 0; i < 20; i++) step();
        enable = 1'b0; step();
        chk("mode0_level", 32'(level), 32'h5);
        drain();

        // mode 1: steady value, a change, then long enough to wrap the timestamp
        pins_in = 8'h01; step(); step(); step(); step();
        mode = 1'b1; sample_div = 8'd1; enable = 1'b1;
        for (int i = 0; i < 13; i++) step();
        pins_in = 8'h03;
        for (int i = 0; i < 30; i++) step();
        enable = 1'b0; step();
        drain();

        // overflow, pop+push while full, clear, and drop-vs-clear priority
        mode = 1'b0; sample_div = 8'd0; enable = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("ovf_level", 32'(level), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'h1);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("full_popush_level", 32'(level), 32'(DEPTH));
        clear_overflow = 1'b1; step();
        chk("drop_beats_clear", 32'(overflow), 32'h1);
        enable = 1'b0; step();
        chk("ovf_cleared", 32'(overflow), 32'h0);
        clear_overflow = 1'b0;
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) pins_in = CH'($urandom);
            if ($urandom_range(40) == 0) enable = ~enable;
            if ($urandom_range(30) == 0) mode = ~mode;
            if ($urandom_range(20) == 0) sample_div = DW'($urandom_range(5));
            rd_en = ($urandom_range(2) == 0);
            clear_overflow = ($urandom_range(15) == 0);
            step();
        end
        enable = 1'b0; clear_overflow = 1'b0;
        drain();

        // asynchronous reset with entries queued
        mode = 1'b0; sample_div = 8'd0; enable = 1'b1;
        step(); step(); step();
        enable = 1'b0;
        chk("pre_reset_level", 32'(level), 32'h3);
        #1 rst = 1'b0;
        reset_model();
        #1;
        chk("async_level", 32'(level), 32'h0);
        chk("async_valid", 32'(rd_valid), 32'h0);
        step(); step();
        rst = 1'b1;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pin_capture.md
Name: pin_capture

Overview:
- Parametrised logic-analyser front end for the board's parallel input pins.
- Per channel: synchronise, then glitch-filter with a hysteresis filter (output changes only when the last FILTER_LEN samples agree).
- Samples the filtered vector on a programmable tick and stores snapshots, optionally timestamped, in a FIFO.
- Sits between the pin bank and main_module; the SPI side drains the FIFO via a valid/pop handshake.

Parameters:
- CHANNELS, 8: number of input pins captured.
- FILTER_LEN, 2: filter agreement length in clk cycles, >=1; 1 = pass-through after the synchroniser.
- DEPTH, 16: FIFO entries; power of two, >=2.
- TS_WIDTH, 16: timestamp width.
- DIV_WIDTH, 16: sample divider width.

Ports:
- clk  in  1  system clock (16 MHz).
- rst  in  1  asynchronous active-low reset.
- pins_in  in  CHANNELS  raw asynchronous pin levels.
- enable  in  1  capture run/stop.
- sample_div  in  DIV_WIDTH  sample period = sample_div+1 clk cycles.
- mode  in  1  0 = store every tick; 1 = store on change only.
- rd_en  in  1  pop request.
- rd_data  out  ENTRY_W  head entry; {timestamp, filtered} or {filtered}.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- level  out  clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky: a sample was dropped.
- clear_overflow  in  1  clears overflow.
- filtered  out  CHANNELS  live filtered levels (debug).

Behaviour:
- Reset: asserting rst (low) asynchronously clears all state, mid-operation included. Synchroniser, filter state, filtered, counters, level, rd_valid and overflow all go to 0. FIFO becomes empty; rd_data = 0.
- Synchroniser: 2 flops per channel.
- Filter, per channel, per clk:
  - Shift register of the last FILTER_LEN synchronised samples.
  - All ones -> filtered = 1; all zeros -> filtered = 0; otherwise hold.
  - Latency from pin edge to filtered: 2+FILTER_LEN clk cycles.
- Tick generator:
  - div_cnt counts 0..sample_div; tick asserts on the cycle div_cnt >= sample_div, then div_cnt returns to 0.
  - sample_div = 0 gives a tick every cycle.
  - A sample_div reduced below div_cnt takes effect immediately: tick on the next cycle.
  - enable low: div_cnt held at 0, no ticks.
- Timestamp:
  - ts_cnt increments on each tick and wraps modulo 2^TS_WIDTH.
  - A rising edge of enable resets ts_cnt to 0; the first stored entry carries ts 0.
- Push decision on a tick:
  - mode 0: always push.
  - mode 1: push when filtered differs from the last pushed value, on the first tick after enable rises, or when ts_cnt = all ones (time-reference marker).
- FIFO:
  - First-word-fall-through, registered write. The entry pushed at tick cycle T is visible on rd_data with rd_valid = 1 at T+1 if the FIFO was empty.
  - Pop happens when rd_en && rd_valid; rd_en while empty is ignored.
  - Push while full without a same-cycle pop: entry dropped, overflow set. Push and pop in the same cycle while full: both occur, no overflow.
  - Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- overflow: cleared by clear_overflow; a same-cycle overflow event wins over the clear (stays 1).
- enable falling: ticks stop; FIFO contents remain readable; a pending filter state is unaffected.

Optional Feature:
- Macro PIN_CAPTURE_TIMESTAMP_EN.
- Defined: ENTRY_W = TS_WIDTH+CHANNELS, rd_data = {ts, filtered}, and the mode-1 wrap marker push is active.
- Undefined: ENTRY_W = CHANNELS, the ts_cnt logic is not built, and there is no wrap marker push.

Decomposition:
- Package pin_capture_pkg holds:
  - the ENTRY_W computation;
  - the LEVEL_W = clog2(DEPTH)+1 helper;
  - mode encodings MODE_ALL = 0 and MODE_CHANGE = 1.
- One sub-module, pin_filter: a single-channel 2-flop synchroniser plus FILTER_LEN hysteresis filter, instantiated CHANNELS times via generate.
- The FIFO stays inline.

Test Plan:
- Reset/latency: release rst, FILTER_LEN = 2, drive pins_in 0x00 -> 0xA5 -> filtered = 0xA5 exactly 4 clk cycles later; all outputs 0 during reset.
- Glitch rejection: 1-cycle pulse on channel 0 with FILTER_LEN = 3 -> filtered stays 0x00 and no mode-1 entry is pushed. A 3-cycle pulse -> filtered[0] toggles.
- Mode 0 sampling: sample_div = 3, enable for 20 cycles, no pops -> 5 entries, ts 0..4, level = 5.
- Mode 1 change-only:
  - pins 0x01 steady, then 0x03 at tick 6 -> entries (ts 0, 0x01) and (ts 6, 0x03) only.
  - With TS_WIDTH = 4, a marker entry appears at ts 15.
- Overflow: DEPTH = 4, mode 0, sample_div = 0, no pops -> level saturates at 4, overflow = 1, head entry is ts 0. Pop and push in the same full cycle -> level stays 4, no further drops. clear_overflow -> overflow = 0.
- Async reset mid-capture: assert rst while level = 3 -> level = 0 and rd_valid = 0 immediately, without a clk edge.
